// File: rtl/operand_issue_pkg.sv
// Shared widths, opcode constants and the scoreboard entry type for the
// operand issue stage.
package operand_issue_pkg;

  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
  localparam int OPW  = 3;

  localparam logic [OPW-1:0] OP_NOP = '0;

  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/operand_issue_if.sv
// Issue handshake plus the ALU-pipe operand/result bus.
// master = instruction source and ALU pipe, slave = issue stage.
interface operand_issue_if;
  import operand_issue_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [AW-1:0]  in_rs1;
  logic [AW-1:0]  in_rs2;
  logic [AW-1:0]  in_rd;
  logic           in_we;
  logic [OPW-1:0] in_op;
  logic [DW-1:0]  RD1;
  logic [DW-1:0]  RD2;
  logic [OPW-1:0] INop;
  logic [DW-1:0]  WD;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_we, in_op, WD,
    input  in_ready, RD1, RD2, INop
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_we, in_op, WD,
    output in_ready, RD1, RD2, INop
  );

endinterface

// File: rtl/operand_issue_regfile.sv
// NREG x DW register file: three combinational read ports, one synchronous
// write port, cleared on async reset, r0 reads zero and ignores writes.
module operand_issue_regfile
  import operand_issue_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  input  logic [AW-1:0] raddr3,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] rdata3
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // No write-through: a read in the writeback cycle returns the old value.
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
  assign rdata3 = (raddr3 == '0) ? '0 : regs[raddr3];

endmodule

// File: rtl/operand_issue.sv
// Issue stage: reads operands for the ALU pipe, tracks in-flight writes in a
// LAT-deep scoreboard and stalls RAW hazards; OPERAND_ISSUE_FWD_EN adds WD bypass.
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_issue_if.slave io,
  input  logic [AW-1:0]  dbg_addr,
  output logic [DW-1:0]  dbg_data,
  output logic [31:0]    retired
);

  sb_entry_t     sb [1:LAT];
  logic [LAT:1]  m1;
  logic [LAT:1]  m2;
  logic          haz1;
  logic          haz2;
  logic          fwd1;
  logic          fwd2;
  logic          ready;
  logic          issue;
  logic          wb_en;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
`ifdef OPERAND_ISSUE_FWD_EN
  logic          newer1;
  logic          newer2;
`endif

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 1; k <= LAT; k++) begin
      m1[k] = sb[k].v && sb[k].we && (sb[k].rd == io.in_rs1) && (io.in_rs1 != '0);
      m2[k] = sb[k].v && sb[k].we && (sb[k].rd == io.in_rs2) && (io.in_rs2 != '0);
    end
`ifdef OPERAND_ISSUE_FWD_EN
    // Only the oldest entry lines up with WD; any newer producer must stall.
    newer1 = 1'b0;
    newer2 = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      newer1 = newer1 | m1[k];
      newer2 = newer2 | m2[k];
    end
    haz1 = newer1;
    haz2 = newer2;
    fwd1 = m1[LAT] && !newer1;
    fwd2 = m2[LAT] && !newer2;
`else
    haz1 = |m1;
    haz2 = |m2;
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`endif
  end

  assign ready       = rst_n && !haz1 && !haz2;
  assign issue       = io.in_valid && ready;
  assign io.in_ready = ready;
  assign io.RD1      = issue ? (fwd1 ? io.WD : rdata1) : '0;
  assign io.RD2      = issue ? (fwd2 ? io.WD : rdata2) : '0;
  assign io.INop     = issue ? io.in_op : OP_NOP;

  assign wb_en = sb[LAT].v && sb[LAT].we && (sb[LAT].rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= LAT; k++) sb[k] <= '0;
      retired <= '0;
    end else begin
      sb[1] <= issue ? sb_entry_t'{v: 1'b1, we: io.in_we, rd: io.in_rd} : '0;
      for (int k = 2; k <= LAT; k++) sb[k] <= sb[k-1];
      if (wb_en) retired <= retired + 32'd1;
    end
  end

  operand_issue_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (sb[LAT].rd),
    .wdata  (io.WD),
    .raddr1 (io.in_rs1),
    .raddr2 (io.in_rs2),
    .raddr3 (dbg_addr),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .rdata3 (dbg_data)
  );

endmodule
